// File: rtl/fft_stage_sequencer.sv
// ----------------------------------------------------------------------------
// fft_stage_sequencer
//
// Stage and address sequencer for a radix-2 FFT datapath. It runs
// L = log2(N) stages. In each stage it issues groups of BFLY butterflies,
// one group per unstalled cycle. It then waits DELAY drain cycles for the
// datapath to write results back before the next stage begins. The SRAM
// ping-pong bank flips at the end of every stage. A busy-cycle watchdog can
// force the sequencer into DONE.
//
// Optional feature macro: FFT_SEQ_PERF_EN
//   When defined, o_stall_cycles counts RUN cycles that have i_stall high.
//   The count saturates and is cleared on start.
//   When undefined, no counter is built and o_stall_cycles is tied to 0.
//
// Ports
//   clk                    clock
//   i_resetn               asynchronous active-low reset
//   i_start                start pulse, honoured only in IDLE/DONE
//   i_log2n                transform size (log2), clamped and latched at start
//   i_stall                hold issue for the next issue slot
//   i_cycle_limit          watchdog limit in busy cycles, 0 disables it
//   o_busy                 RUN or DRAIN
//   o_valid_data           a butterfly group is issued this cycle
//   o_new_stage_trigger    one-cycle pulse when a stage >= 1 begins
//   o_sram_read_register   read bank (the write bank is its complement)
//   o_stage                current stage
//   o_calc_index           first butterfly index of the issued group
//   o_stride               N >> (stage+1)
//   o_stride_index_offset  o_stride / (2*BFLY), floor
//   o_group_offset         max(2, o_stride_index_offset+1)
//   o_fft_done             high while in DONE
//   o_timeout              DONE was reached through the watchdog
//   o_stall_cycles         stalled RUN cycles (feature macro)
// ----------------------------------------------------------------------------
module fft_stage_sequencer #(
  parameter int MAX_LOG2N = 10,
  parameter int BFLY      = 2,
  parameter int DELAY     = 10,
  parameter int CNT_W     = 12
) (
  input  logic                 clk,
  input  logic                 i_resetn,
  input  logic                 i_start,
  input  logic [3:0]           i_log2n,
  input  logic                 i_stall,
  input  logic [CNT_W-1:0]     i_cycle_limit,
  output logic                 o_busy,
  output logic                 o_valid_data,
  output logic                 o_new_stage_trigger,
  output logic                 o_sram_read_register,
  output logic [3:0]           o_stage,
  output logic [MAX_LOG2N-1:0] o_calc_index,
  output logic [MAX_LOG2N-1:0] o_stride,
  output logic [MAX_LOG2N-1:0] o_stride_index_offset,
  output logic [MAX_LOG2N-1:0] o_group_offset,
  output logic                 o_fft_done,
  output logic                 o_timeout,
  output logic [CNT_W-1:0]     o_stall_cycles
);

  localparam int AW    = MAX_LOG2N;
  localparam int LOG2B = $clog2(BFLY);
  // The drain counter only needs to reach DELAY-1.
  localparam int DW    = $clog2(DELAY);

  localparam logic [3:0]    MIN_L      = 4'(LOG2B + 1);
  localparam logic [3:0]    MAX_L      = 4'(MAX_LOG2N);
  localparam logic [AW-1:0] BFLY_A     = AW'(BFLY);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;

  logic [3:0]      l_q, l_d;
  logic [3:0]      stage_q, stage_d;
  logic [AW-1:0]   calc_q, calc_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic            valid_q, valid_d;
  logic            trig_q, trig_d;
  logic            bank_q, bank_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            busy_q;
  logic [AW-1:0]   stride_q, sio_q, go_q;

  // --------------------------------------------------------------------------
  // Decode of the current cycle
  // --------------------------------------------------------------------------
  logic            start_ok;
  logic [3:0]      l_start;
  logic [AW-1:0]   last_calc;
  logic            last_issue;
  logic            drain_end;
  logic            last_stage;
  logic            busy_now;
  logic [CNT_W-1:0] wd_inc;
  logic            wd_hit;
  logic            natural_done;

  assign start_ok = i_start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    l_start = i_log2n;
    if (i_log2n < MIN_L) begin
      l_start = MIN_L;
    end else if (i_log2n > MAX_L) begin
      l_start = MAX_L;
    end
  end

  // The last group of a stage starts at N/2 - BFLY.
  assign last_calc    = (AW'(1) << (l_q - 4'd1)) - BFLY_A;
  assign last_issue   = (state_q == S_RUN) && valid_q && (calc_q == last_calc);
  assign drain_end    = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);
  assign last_stage   = (stage_q == (l_q - 4'd1));
  assign natural_done = drain_end && last_stage;

  assign busy_now = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wd_inc   = wd_q + CNT_W'(1);
  // wd_q holds the number of busy cycles before this one. The limit is hit
  // when this cycle completes the limit-th busy cycle.
  assign wd_hit   = busy_now && (i_cycle_limit != '0) && (wd_inc == i_cycle_limit);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (wd_hit)          state_d = S_DONE;
        else if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Natural completion takes priority over a coincident watchdog hit.
        if (natural_done)   state_d = S_DONE;
        else if (wd_hit)    state_d = S_DONE;
        else if (drain_end) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and sequencing counters (next values)
  // --------------------------------------------------------------------------
  always_comb begin
    l_d       = l_q;
    stage_d   = stage_q;
    calc_d    = calc_q;
    drain_d   = drain_q;
    wd_d      = wd_q;
    valid_d   = 1'b0;
    trig_d    = 1'b0;
    bank_d    = bank_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          l_d       = l_start;
          stage_d   = 4'd0;
          calc_d    = '0;
          drain_d   = '0;
          wd_d      = '0;
          valid_d   = !i_stall;
          bank_d    = 1'b0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_RUN: begin
        wd_d = wd_inc;
        if (wd_hit) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (last_issue) begin
          drain_d = '0;
        end else begin
          // The stall seen now decides whether the next slot issues.
          valid_d = !i_stall;
          if (valid_q) calc_d = calc_q + BFLY_A;
        end
      end
      S_DRAIN: begin
        wd_d    = wd_inc;
        drain_d = drain_q + DW'(1);
        if (natural_done) begin
          bank_d = ~bank_q;
          done_d = 1'b1;
        end else if (wd_hit) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else if (drain_end) begin
          bank_d  = ~bank_q;
          stage_d = stage_q + 4'd1;
          calc_d  = '0;
          valid_d = !i_stall;
          trig_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-stage address parameters. They are computed from the values that the
  // stage is about to use and are loaded only when a stage begins.
  // --------------------------------------------------------------------------
  logic            stage_load;
  logic [3:0]      stride_sh;
  logic [AW-1:0]   stride_new, sio_new, sio_p1, go_new;

  assign stage_load = (state_d == S_RUN) && (state_q != S_RUN);
  assign stride_sh  = l_d - 4'd1 - stage_d;
  assign stride_new = AW'(1) << stride_sh;
  assign sio_new    = stride_new >> (LOG2B + 1);
  assign sio_p1     = sio_new + AW'(1);
  assign go_new     = (sio_p1 < AW'(2)) ? AW'(2) : sio_p1;

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      l_q       <= '0;
      stage_q   <= '0;
      calc_q    <= '0;
      drain_q   <= '0;
      wd_q      <= '0;
      valid_q   <= 1'b0;
      trig_q    <= 1'b0;
      bank_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      stride_q  <= '0;
      sio_q     <= '0;
      go_q      <= '0;
    end else begin
      l_q       <= l_d;
      stage_q   <= stage_d;
      calc_q    <= calc_d;
      drain_q   <= drain_d;
      wd_q      <= wd_d;
      valid_q   <= valid_d;
      trig_q    <= trig_d;
      bank_q    <= bank_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == S_RUN) || (state_d == S_DRAIN);
      if (stage_load) begin
        stride_q <= stride_new;
        sio_q    <= sio_new;
        go_q     <= go_new;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall performance counter
  // --------------------------------------------------------------------------
`ifdef FFT_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_RUN) && i_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign o_stall_cycles  = '0;
`endif

  assign o_busy                = busy_q;
  assign o_valid_data          = valid_q;
  assign o_new_stage_trigger   = trig_q;
  assign o_sram_read_register  = bank_q;
  assign o_stage               = stage_q;
  assign o_calc_index          = calc_q;
  assign o_stride              = stride_q;
  assign o_stride_index_offset = sio_q;
  assign o_group_offset        = go_q;
  assign o_fft_done            = done_q;
  assign o_timeout             = timeout_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int MAX_LOG2N = 10;
  localparam int BFLY      = 2;
  localparam int DELAY     = 10;
  localparam int CNT_W     = 12;
  localparam int AW        = MAX_LOG2N;
  localparam int MAXC      = 4096;

  logic             clk = 1'b0;
  logic             i_resetn;
  logic             i_start;
  logic [3:0]       i_log2n;
  logic             i_stall;
  logic [CNT_W-1:0] i_cycle_limit;
  logic             o_busy, o_valid_data, o_new_stage_trigger, o_sram_read_register;
  logic [3:0]       o_stage;
  logic [AW-1:0]    o_calc_index, o_stride, o_stride_index_offset, o_group_offset;
  logic             o_fft_done, o_timeout;
  logic [CNT_W-1:0] o_stall_cycles;

  always #5 clk = ~clk;

  fft_stage_sequencer #(
    .MAX_LOG2N(MAX_LOG2N), .BFLY(BFLY), .DELAY(DELAY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .i_resetn(i_resetn), .i_start(i_start), .i_log2n(i_log2n),
    .i_stall(i_stall), .i_cycle_limit(i_cycle_limit),
    .o_busy(o_busy), .o_valid_data(o_valid_data),
    .o_new_stage_trigger(o_new_stage_trigger),
    .o_sram_read_register(o_sram_read_register), .o_stage(o_stage),
    .o_calc_index(o_calc_index), .o_stride(o_stride),
    .o_stride_index_offset(o_stride_index_offset),
    .o_group_offset(o_group_offset), .o_fft_done(o_fft_done),
    .o_timeout(o_timeout), .o_stall_cycles(o_stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  // stimulus per cycle (cycle 0 = the start cycle of a run)
  bit stall_pat[MAXC];
  bit start_pat[MAXC];

  // observations per cycle
  bit ob_valid[MAXC], ob_trig[MAXC], ob_busy[MAXC], ob_done[MAXC], ob_to[MAXC], ob_bank[MAXC];
  int ob_calc[MAXC], ob_stride[MAXC], ob_stage[MAXC], ob_sio[MAXC], ob_go[MAXC], ob_scnt[MAXC];

  // reference timeline
  bit ex_valid[MAXC], ex_trig[MAXC], ex_busy[MAXC], ex_run[MAXC];
  int ex_calc[MAXC], ex_stage[MAXC];
  int ex_done_at, ex_l, ex_stalls;
  bit ex_timeout;

  task automatic clear_pats();
    for (int c = 0; c < MAXC; c++) begin
      stall_pat[c] = 1'b0;
      start_pat[c] = 1'b0;
    end
  endtask

  // Reference model: lays out the run as a timeline. Each stage issues
  // N/(2*BFLY) groups, one per slot whose preceding-cycle stall is low,
  // then drains for DELAY cycles. The watchdog ends the run after
  // `limit` busy cycles unless natural completion comes at the same time.
  task automatic build_model(input int log2n, input int limit);
    int n, iss, t, got, d_nat, cnt;
    ex_l = log2n;
    if (ex_l < $clog2(BFLY) + 1) ex_l = $clog2(BFLY) + 1;
    if (ex_l > MAX_LOG2N) ex_l = MAX_LOG2N;
    n   = 1 << ex_l;
    iss = n / (2 * BFLY);
    for (int c = 0; c < MAXC; c++) begin
      ex_valid[c] = 0; ex_trig[c] = 0; ex_busy[c] = 0; ex_run[c] = 0;
      ex_calc[c] = 0; ex_stage[c] = -1;
    end
    t = 1;
    for (int k = 0; k < ex_l; k++) begin
      if (k > 0) ex_trig[t] = 1;
      got = 0;
      while (got < iss && t < MAXC - DELAY - 2) begin
        ex_stage[t] = k; ex_busy[t] = 1; ex_run[t] = 1;
        if (!stall_pat[t-1]) begin
          ex_valid[t] = 1;
          ex_calc[t]  = got * BFLY;
          got++;
        end
        t++;
      end
      for (int d = 0; d < DELAY; d++) begin
        ex_stage[t] = k; ex_busy[t] = 1;
        t++;
      end
    end
    d_nat = t;
    if (limit != 0 && 1 + limit < d_nat) begin
      ex_done_at = 1 + limit; ex_timeout = 1;
    end else begin
      ex_done_at = d_nat; ex_timeout = 0;
    end
    for (int c = ex_done_at; c < MAXC; c++) begin
      ex_valid[c] = 0; ex_trig[c] = 0; ex_busy[c] = 0; ex_run[c] = 0;
    end
    cnt = 0;
    for (int c = 1; c < ex_done_at; c++) if (ex_run[c] && stall_pat[c]) cnt++;
`ifdef FFT_SEQ_PERF_EN
    ex_stalls = (cnt > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : cnt;
`else
    ex_stalls = 0;
`endif
  endtask

  // Plays the stimulus arrays and records the outputs of every cycle.
  task automatic do_run(input int log2n, input int limit, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ob_valid[c]  = o_valid_data;
      ob_trig[c]   = o_new_stage_trigger;
      ob_busy[c]   = o_busy;
      ob_done[c]   = o_fft_done;
      ob_to[c]     = o_timeout;
      ob_bank[c]   = o_sram_read_register;
      ob_calc[c]   = int'(o_calc_index);
      ob_stride[c] = int'(o_stride);
      ob_stage[c]  = int'(o_stage);
      ob_sio[c]    = int'(o_stride_index_offset);
      ob_go[c]     = int'(o_group_offset);
      ob_scnt[c]   = int'(o_stall_cycles);
      i_start       = start_pat[c];
      i_stall       = stall_pat[c];
      i_log2n       = 4'(log2n);
      i_cycle_limit = CNT_W'(limit);
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    $display("run log2n=%0d limit=%0d cycles=%0d done=%0b timeout=%0b", log2n, limit, ncyc,
             o_fft_done, o_timeout);
  endtask

  task automatic test_reset();
    logic [64:0] outs;
    i_resetn = 1'b0; i_start = 0; i_stall = 0; i_log2n = 4'd3; i_cycle_limit = '0;
    repeat (2) @(posedge clk);
    #1;
    outs = {o_busy, o_valid_data, o_new_stage_trigger, o_sram_read_register, o_stage,
            o_calc_index, o_stride, o_stride_index_offset, o_group_offset, o_fft_done,
            o_timeout, o_stall_cycles};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(negedge clk); i_resetn = 1'b1;

    // reset in the middle of stage 1 of an N=64 run
    clear_pats(); start_pat[0] = 1;
    do_run(6, 0, 31);
    total++;
    if (ob_stage[30] !== 1 || ob_busy[30] !== 1'b1) begin
      bad++; $display("FAIL midrun_stage got=%0d/%0b want=1/1", ob_stage[30], ob_busy[30]);
    end
    #2 i_resetn = 1'b0;
    #1;
    outs = {o_busy, o_valid_data, o_new_stage_trigger, o_sram_read_register, o_stage,
            o_calc_index, o_stride, o_stride_index_offset, o_group_offset, o_fft_done,
            o_timeout, o_stall_cycles};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL async_reset_outputs got=%h want=0", outs); end
    @(negedge clk); i_resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_valid_data !== 1'b0 || o_fft_done !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got=%0b%0b%0b want=000", o_busy, o_valid_data, o_fft_done);
    end
  endtask

  task automatic test_n8();
    clear_pats(); start_pat[0] = 1;
    do_run(3, 0, 40);
    total++; if (ob_valid[1] !== 1 || ob_valid[2] !== 1 || ob_valid[3] !== 0) begin
      bad++; $display("FAIL n8_valid got=%0b%0b%0b want=110", ob_valid[1], ob_valid[2], ob_valid[3]); end
    total++; if (ob_calc[1] !== 0 || ob_calc[2] !== 2) begin
      bad++; $display("FAIL n8_calc got=%0d,%0d want=0,2", ob_calc[1], ob_calc[2]); end
    total++; if (ob_stride[1] !== 4 || ob_sio[1] !== 1 || ob_go[1] !== 2 || ob_bank[1] !== 0) begin
      bad++; $display("FAIL n8_stage0 got=%0d/%0d/%0d/%0b want=4/1/2/0", ob_stride[1], ob_sio[1], ob_go[1], ob_bank[1]); end
    total++; if (ob_trig[13] !== 1 || ob_trig[12] !== 0 || ob_stride[13] !== 2 || ob_stage[13] !== 1) begin
      bad++; $display("FAIL n8_trig13 got=%0b%0b s=%0d st=%0d want=10 s=2 st=1", ob_trig[12], ob_trig[13], ob_stride[13], ob_stage[13]); end
    total++; if (ob_trig[25] !== 1 || ob_stride[25] !== 1 || ob_sio[25] !== 0 || ob_go[25] !== 2) begin
      bad++; $display("FAIL n8_trig25 got=%0b s=%0d o=%0d g=%0d want=1 s=1 o=0 g=2", ob_trig[25], ob_stride[25], ob_sio[25], ob_go[25]); end
    total++; if (ob_done[37] !== 1 || ob_done[36] !== 0 || ob_bank[37] !== 1 || ob_to[37] !== 0 || ob_busy[37] !== 0) begin
      bad++; $display("FAIL n8_done got=%0b%0b bank=%0b to=%0b busy=%0b want=01 bank=1 to=0 busy=0", ob_done[36], ob_done[37], ob_bank[37], ob_to[37], ob_busy[37]); end
  endtask

  task automatic test_n8_stall();
    clear_pats(); start_pat[0] = 1; stall_pat[1] = 1;
    do_run(3, 0, 41);
    total++; if (ob_done[0] !== 1 || ob_done[1] !== 0) begin
      bad++; $display("FAIL done_fall got=%0b%0b want=10", ob_done[0], ob_done[1]); end
    total++; if (ob_valid[1] !== 1 || ob_valid[2] !== 0 || ob_valid[3] !== 1 || ob_calc[3] !== 2) begin
      bad++; $display("FAIL stall_valid got=%0b%0b%0b c=%0d want=101 c=2", ob_valid[1], ob_valid[2], ob_valid[3], ob_calc[3]); end
    total++; if (ob_trig[14] !== 1 || ob_trig[13] !== 0 || ob_trig[26] !== 1) begin
      bad++; $display("FAIL stall_trig got=%0b%0b%0b want=011", ob_trig[13], ob_trig[14], ob_trig[26]); end
    total++; if (ob_done[38] !== 1 || ob_done[37] !== 0 || ob_bank[38] !== 1) begin
      bad++; $display("FAIL stall_done got=%0b%0b bank=%0b want=01 bank=1", ob_done[37], ob_done[38], ob_bank[38]); end
  endtask

  task automatic test_clamp();
    int trigs;
    clear_pats(); start_pat[0] = 1;
    do_run(12, 0, 2665);
    total++; if (ob_stride[1] !== 512 || ob_sio[1] !== 128 || ob_go[1] !== 129) begin
      bad++; $display("FAIL clamp_stride got=%0d/%0d/%0d want=512/128/129", ob_stride[1], ob_sio[1], ob_go[1]); end
    trigs = 0;
    for (int c = 1; c < 2665; c++) if (ob_trig[c]) trigs++;
    total++; if (trigs !== 9) begin bad++; $display("FAIL clamp_triggers got=%0d want=9", trigs); end
    total++; if (ob_done[2661] !== 1 || ob_done[2660] !== 0 || ob_bank[2661] !== 0) begin
      bad++; $display("FAIL clamp_done got=%0b%0b bank=%0b want=01 bank=0", ob_done[2660], ob_done[2661], ob_bank[2661]); end
  endtask

  task automatic test_watchdog();
    int vbad;
    clear_pats(); start_pat[0] = 1; start_pat[3] = 1;
    do_run(10, 5, 12);
    total++; if (ob_done[5] !== 0 || ob_done[6] !== 1 || ob_to[6] !== 1 || ob_busy[6] !== 0) begin
      bad++; $display("FAIL wd_done got=%0b%0b to=%0b busy=%0b want=01 to=1 busy=0", ob_done[5], ob_done[6], ob_to[6], ob_busy[6]); end
    vbad = 0;
    for (int c = 6; c < 12; c++) if (ob_valid[c] !== 0) vbad++;
    total++; if (vbad !== 0 || ob_valid[5] !== 1) begin
      bad++; $display("FAIL wd_valid got=%0d late valids, v5=%0b want=0, v5=1", vbad, ob_valid[5]); end
    total++; if (ob_calc[4] !== 6) begin
      bad++; $display("FAIL busy_start_ignored got=%0d want=6", ob_calc[4]); end
    // watchdog fires one cycle before natural completion
    clear_pats(); start_pat[0] = 1;
    do_run(3, 35, 40);
    total++; if (ob_to[1] !== 0 || ob_done[36] !== 1 || ob_to[36] !== 1 || ob_done[35] !== 0) begin
      bad++; $display("FAIL wd_early got=to1:%0b d35:%0b d36:%0b to36:%0b want=0,0,1,1", ob_to[1], ob_done[35], ob_done[36], ob_to[36]); end
    // watchdog coincides with natural completion
    clear_pats(); start_pat[0] = 1;
    do_run(3, 36, 40);
    total++; if (ob_done[37] !== 1 || ob_done[36] !== 0 || ob_to[37] !== 0 || ob_bank[37] !== 1) begin
      bad++; $display("FAIL wd_coincide got=d36:%0b d37:%0b to:%0b bank:%0b want=0,1,0,1", ob_done[36], ob_done[37], ob_to[37], ob_bank[37]); end
  endtask

  task automatic test_perf();
    int want;
    clear_pats(); start_pat[0] = 1;
    stall_pat[1] = 1; stall_pat[2] = 1; stall_pat[5] = 1;
    do_run(4, 0, 64);
`ifdef FFT_SEQ_PERF_EN
    want = 3;
`else
    want = 0;
`endif
    total++; if (ob_done[60] !== 1 || ob_done[59] !== 0) begin
      bad++; $display("FAIL perf_done got=%0b%0b want=01", ob_done[59], ob_done[60]); end
    total++; if (ob_scnt[63] !== want) begin
      bad++; $display("FAIL perf_stall_cycles got=%0d want=%0d", ob_scnt[63], want); end
  endtask

  task automatic test_random();
    int log2n, limit, ncyc, n;
    for (int r = 0; r < 8; r++) begin
      clear_pats(); start_pat[0] = 1;
      log2n = $urandom_range(0, 8);
      limit = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 900);
      for (int c = 0; c < MAXC; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
      build_model(log2n, limit);
      ncyc = ex_done_at + 3;
      n = 1 << ex_l;
      do_run(log2n, limit, ncyc);
      for (int c = 1; c < ncyc; c++) begin
        total++;
        if (ob_valid[c] !== ex_valid[c] || ob_trig[c] !== ex_trig[c] || ob_busy[c] !== ex_busy[c]) begin
          bad++; $display("FAIL rnd_ctrl run=%0d c=%0d got=v%0b t%0b b%0b want=v%0b t%0b b%0b", r, c,
                          ob_valid[c], ob_trig[c], ob_busy[c], ex_valid[c], ex_trig[c], ex_busy[c]);
        end
        total++;
        if (ob_done[c] !== (c >= ex_done_at) || ob_to[c] !== ((c >= ex_done_at) && ex_timeout)) begin
          bad++; $display("FAIL rnd_done run=%0d c=%0d got=d%0b to%0b want=d%0b to%0b", r, c,
                          ob_done[c], ob_to[c], c >= ex_done_at, (c >= ex_done_at) && ex_timeout);
        end
        if (ex_valid[c]) begin
          total++;
          if (ob_calc[c] !== ex_calc[c]) begin
            bad++; $display("FAIL rnd_calc run=%0d c=%0d got=%0d want=%0d", r, c, ob_calc[c], ex_calc[c]);
          end
        end
        if (ex_busy[c]) begin
          total++;
          if (ob_stage[c] !== ex_stage[c] || ob_stride[c] !== (n >> (ex_stage[c] + 1)) ||
              ob_sio[c] !== ((n >> (ex_stage[c] + 1)) / (2 * BFLY)) ||
              ob_go[c] !== ((((n >> (ex_stage[c] + 1)) / (2 * BFLY)) + 1 < 2) ? 2 : ((n >> (ex_stage[c] + 1)) / (2 * BFLY)) + 1) ||
              ob_bank[c] !== ex_stage[c][0]) begin
            bad++; $display("FAIL rnd_stage run=%0d c=%0d got=st%0d s%0d o%0d g%0d b%0b want=st%0d s%0d", r, c,
                            ob_stage[c], ob_stride[c], ob_sio[c], ob_go[c], ob_bank[c], ex_stage[c], n >> (ex_stage[c] + 1));
          end
        end
      end
      total++;
      if (ob_scnt[ex_done_at] !== ex_stalls) begin
        bad++; $display("FAIL rnd_stall_cycles run=%0d got=%0d want=%0d", r, ob_scnt[ex_done_at], ex_stalls);
      end
      if (!ex_timeout) begin
        total++;
        if (ob_bank[ex_done_at] !== ex_l[0]) begin
          bad++; $display("FAIL rnd_done_bank run=%0d got=%0b want=%0b", r, ob_bank[ex_done_at], ex_l[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_n8();
    test_n8_stall();
    test_clamp();
    test_watchdog();
    test_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
